alu_result_display: RTL and testbench
=====================================

ALU_RESULT_DISPLAY -- requirements
Module: alu_result_display

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles each digit stays selected; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load  input  1  capture strobe for result/cout; sampled each rising edge.
REQ-005 result  input  8  ALU result R, unsigned 0..255.
REQ-006 cout  input  1  ALU carry out accompanying result.
REQ-007 seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
REQ-008 dp  output  1  decimal point, active-high; shows captured carry.
REQ-009 dig_sel  output  3  one-hot digit enable, active-high: 001 units, 010 tens, 100 hundreds.
REQ-010 busy  output  1  high while a conversion is in progress.

Function
REQ-011 FSM states SHALL be IDLE and CONVERT; reset state IDLE.
REQ-012 load=1 at an edge in IDLE SHALL capture result and cout, clear the BCD scratch, clear the iteration counter, and enter CONVERT.
REQ-013 load while in CONVERT SHALL be ignored, including on the edge that returns to IDLE; no queueing.
REQ-014 CONVERT SHALL perform binary-to-BCD double-dabble, one shift/add-3 iteration per cycle, exactly 8 iterations.
REQ-015 busy SHALL be high for exactly the 8 cycles following the capturing edge; low otherwise.
REQ-016 On the edge ending the 8th iteration the FSM SHALL return to IDLE and load hundreds (0..2), tens, units (0..9) and the captured carry into the display registers in the same edge.
REQ-017 Display registers SHALL hold their value until the next completed conversion; the display never shows partial results.
REQ-018 Scan divider SHALL count 0..SCAN_DIV-1 and wrap; on wrap the digit index SHALL advance units -> tens -> hundreds -> units.
REQ-019 SCAN_DIV=1 SHALL advance the digit every cycle.
REQ-020 Scan SHALL run continuously, independent of FSM state and load.
REQ-021 seg SHALL be the combinational decode of the selected display digit: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex); blanked digit = 00.
REQ-022 dp SHALL equal the stored carry while units is selected, 0 otherwise.
REQ-023 dig_sel SHALL be the one-hot decode of the digit index; exactly one bit high at all times.

Reset
REQ-024 rst=1 at an edge SHALL force: state IDLE, busy=0, display registers 0, stored carry 0, digit index units, divider 0, scratch registers 0.
REQ-025 Post-reset outputs: dig_sel=001, seg=3F, dp=0, busy=0.
REQ-026 rst during CONVERT SHALL abort the conversion; no display update from the aborted operation.
REQ-027 rst SHALL dominate load in the same cycle.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN SHALL select leading-zero blanking.
REQ-029 Defined: hundreds blanked (seg=00) when 0; tens blanked when hundreds and tens both 0; units never blanked.
REQ-030 Undefined: all three digits always decoded, zeros shown as 3F.
REQ-031 Macro SHALL not affect timing, busy, dp or dig_sel.

Verification
REQ-032 Assert rst 2 cycles, release -> dig_sel=001, seg=3F, dp=0, busy=0.
REQ-033 SCAN_DIV=4, load result=255 cout=1 -> busy high 8 cycles; then hundreds seg=5B, tens 6D, units 6D; dp=1 only with dig_sel=001; dig_sel changes every 4 cycles in order 001,010,100,001.
REQ-034 Macro defined, load result=7 -> hundreds and tens seg=00, units 07; macro undefined -> 3F, 3F, 07.
REQ-035 Load result=200, then load result=100 at 3rd busy cycle and at the busy-deassert edge -> display shows 2,0,0; busy pulses once.
REQ-036 Load result=123, assert rst at 4th busy cycle -> busy=0 next cycle, display 0 (units seg=3F); subsequent load result=42 cout=0 -> tens 66, units 5B, dp=0.
REQ-037 SCAN_DIV=1, load result=0 -> dig_sel rotates every cycle; units 3F, upper digits per REQ-029/REQ-030.

Source files
------------

// File: rtl/alu_result_display.sv
// rtl/alu_result_display.sv - ALU result to 3-digit multiplexed 7-segment display via double-dabble BCD.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module alu_result_display #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] result,
  input  logic       cout,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] dig_sel,
  output logic       busy
);

  typedef enum logic {IDLE, CONVERT} state_t;

  localparam logic [15:0] DIV_MAX = 16'(SCAN_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  iter_q, iter_d;
  logic        cap_carry_q, cap_carry_d;
  logic [3:0]  hun_q, hun_d;
  logic [3:0]  ten_q, ten_d;
  logic [3:0]  unit_q, unit_d;
  logic        carry_q, carry_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  idx_q, idx_d;

  logic [11:0] bcd_adj;
  logic [19:0] shifted;
  logic        last_iter;
  logic        div_wrap;
  logic [3:0]  digit;
  logic        blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign last_iter = (iter_q == 3'd7);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONVERT;
      CONVERT: if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CONVERT);
  end

  // One double-dabble step: add 3 to any nibble >= 5, then shift the whole scratch left.
  assign bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
  assign shifted = {bcd_adj, bin_q} << 1;

  always_comb begin
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    iter_d      = iter_q;
    cap_carry_d = cap_carry_q;
    hun_d       = hun_q;
    ten_d       = ten_q;
    unit_d      = unit_q;
    carry_d     = carry_q;
    if (state_q == IDLE) begin
      if (load) begin
        bin_d       = result;
        cap_carry_d = cout;
        bcd_d       = 12'd0;
        iter_d      = 3'd0;
      end
    end else begin
      bin_d  = shifted[7:0];
      bcd_d  = shifted[19:8];
      iter_d = iter_q + 3'd1;
      if (last_iter) begin
        hun_d   = shifted[19:16];
        ten_d   = shifted[15:12];
        unit_d  = shifted[11:8];
        carry_d = cap_carry_q;
      end
    end
  end

  assign div_wrap = (div_q == DIV_MAX);

  always_comb begin
    div_d = div_wrap ? 16'd0 : div_q + 16'd1;
    idx_d = idx_q;
    if (div_wrap) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q       <= 8'd0;
      bcd_q       <= 12'd0;
      iter_q      <= 3'd0;
      cap_carry_q <= 1'b0;
      hun_q       <= 4'd0;
      ten_q       <= 4'd0;
      unit_q      <= 4'd0;
      carry_q     <= 1'b0;
      div_q       <= 16'd0;
      idx_q       <= 2'd0;
    end else begin
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
      cap_carry_q <= cap_carry_d;
      hun_q       <= hun_d;
      ten_q       <= ten_d;
      unit_q      <= unit_d;
      carry_q     <= carry_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
    end
  end

  always_comb begin
    dig_sel = 3'b001;
    digit   = unit_q;
    blank   = 1'b0;
    case (idx_q)
      2'd1: begin
        dig_sel = 3'b010;
        digit   = ten_q;
`ifdef LEADING_ZERO_BLANK_EN
        blank   = (hun_q == 4'd0) && (ten_q == 4'd0);
`endif
      end
      2'd2: begin
        dig_sel = 3'b100;
        digit   = hun_q;
`ifdef LEADING_ZERO_BLANK_EN
        blank   = (hun_q == 4'd0);
`endif
      end
      default: begin
        dig_sel = 3'b001;
        digit   = unit_q;
      end
    endcase
    seg = blank ? 7'h00 : decode(digit);
    dp  = carry_q && (idx_q == 2'd0);
  end

endmodule

// File: tb/tb_alu_result_display.sv
// tb/tb_alu_result_display.sv - self-checking bench for alu_result_display (SCAN_DIV=4 and SCAN_DIV=1 instances).
module tb_alu_result_display;

  logic       clk = 1'b0;
  logic       rst, load, cout;
  logic [7:0] result;
  logic [6:0] seg4, seg1;
  logic       dp4, dp1, busy4, busy1;
  logic [2:0] sel4, sel1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_result_display #(.SCAN_DIV(4)) u4 (
    .clk(clk), .rst(rst), .load(load), .result(result), .cout(cout),
    .seg(seg4), .dp(dp4), .dig_sel(sel4), .busy(busy4));

  alu_result_display #(.SCAN_DIV(1)) u1 (
    .clk(clk), .rst(rst), .load(load), .result(result), .cout(cout),
    .seg(seg1), .dp(dp1), .dig_sel(sel1), .busy(busy1));

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZSEG = 7'h00;
`else
  localparam logic [6:0] ZSEG = 7'h3F;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int disp, input int idx);
    int  d;
    bit  blank;
    d = (idx == 0) ? disp % 10 : (idx == 1) ? (disp / 10) % 10 : disp / 100;
    blank = 0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx == 2 && disp < 100) || (idx == 1 && disp < 10);
`endif
    return blank ? 7'h00 : seg_of(d);
  endfunction

  // Behavioural model: remaining busy cycles, shown value, cycles since reset.
  int m_busy, m_disp, m_cap, tick;
  bit m_carry, m_capc, model_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_disp = 0; m_carry = 0; tick = 0; model_ok = 1;
    end else if (model_ok) begin
      tick++;
      if (m_busy == 0) begin
        if (load) begin m_cap = result; m_capc = cout; m_busy = 8; end
      end else begin
        m_busy--;
        if (m_busy == 0) begin m_disp = m_cap; m_carry = m_capc; end
      end
    end
  end

  always @(negedge clk) begin
    int i4, i1;
    if (model_ok) begin
      i4 = (tick / 4) % 3;
      i1 = tick % 3;
      chk("m4_busy", busy4, m_busy != 0);
      chk("m4_sel", sel4, 1 << i4);
      chk("m4_seg", seg4, model_seg(m_disp, i4));
      chk("m4_dp", dp4, m_carry && i4 == 0);
      chk("m1_busy", busy1, m_busy != 0);
      chk("m1_sel", sel1, 1 << i1);
      chk("m1_seg", seg1, model_seg(m_disp, i1));
      chk("m1_dp", dp1, m_carry && i1 == 0);
    end
  end

  task automatic do_load(input int r, input bit c);
    load = 1; result = 8'(r); cout = c;
    @(negedge clk);
    load = 0;
  endtask

  task automatic look(input string name, input logic [2:0] want, input logic [6:0] s, input bit d);
    int t = 0;
    while (sel4 != want && t < 30) begin @(negedge clk); t++; end
    chk({name, "_found"}, sel4 == want, 1);
    chk({name, "_seg"}, seg4, s);
    chk({name, "_dp"}, dp4, d);
  endtask

  initial begin
    int n, pulses;
    bit prev;
    logic [2:0] ps;
    rst = 1; load = 0; result = 0; cout = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sel", sel4, 3'b001);
    chk("rst_seg", seg4, 7'h3F);
    chk("rst_dp", dp4, 0);
    chk("rst_busy", busy4, 0);
    rst = 0;

    do_load(255, 1);
    n = 0;
    repeat (12) begin if (busy4) n++; @(negedge clk); end
    chk("busy_len_255", n, 8);
    look("h255", 3'b100, 7'h5B, 0);
    look("t255", 3'b010, 7'h6D, 0);
    look("u255", 3'b001, 7'h6D, 1);

    do_load(7, 0);
    repeat (10) @(negedge clk);
    look("h7", 3'b100, ZSEG, 0);
    look("t7", 3'b010, ZSEG, 0);
    look("u7", 3'b001, 7'h07, 0);

    load = 1; result = 200; cout = 0;
    pulses = 0; n = 0; prev = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      load = (k == 3 || k == 8);
      result = 100;
      if (busy4 && !prev) pulses++;
      if (busy4) n++;
      prev = busy4;
    end
    load = 0;
    chk("ign_pulses", pulses, 1);
    chk("ign_len", n, 8);
    look("h200", 3'b100, 7'h5B, 0);
    look("t200", 3'b010, 7'h3F, 0);
    look("u200", 3'b001, 7'h3F, 0);

    load = 1; result = 123; cout = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      rst = (k == 4);
      load = (k == 4);
      if (k == 5) chk("abort_busy", busy4, 0);
    end
    rst = 0; load = 0;
    look("u_abort", 3'b001, 7'h3F, 0);

    do_load(42, 0);
    repeat (10) @(negedge clk);
    look("t42", 3'b010, 7'h66, 0);
    look("u42", 3'b001, 7'h5B, 0);
    look("h42", 3'b100, ZSEG, 0);

    do_load(0, 0);
    repeat (10) @(negedge clk);
    ps = sel1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fast_rot", sel1, {ps[1:0], ps[2]});
      chk("fast_seg", seg1, (sel1 == 3'b001) ? 7'h3F : ZSEG);
      ps = sel1;
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
